// File: rtl/pe_conv1d_scheduler_pkg.sv
// Shared scheduler types: FSM state encoding and per-stream skid depth.
// Imported by the scheduler top and its skid buffer.
package pe_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } schedState_t;

  localparam int SkidDepth = 2;

endpackage

// File: rtl/pe_conv1d_scheduler_if.sv
// PE-facing token streams: W/I/O tokens toward the PE (valid/ready), results back (always accepted).
// master = scheduler side, slave = PE side.
interface pe_conv1d_scheduler_if #(
  parameter int DataWidth = 32
);
  logic [DataWidth-1:0] pe_w_data;
  logic [DataWidth-1:0] pe_i_data;
  logic [DataWidth-1:0] pe_o_data;
  logic                 pe_w_valid;
  logic                 pe_i_valid;
  logic                 pe_o_valid;
  logic                 pe_w_rdy;
  logic                 pe_i_rdy;
  logic                 pe_o_rdy;
  logic                 pe_out_rdy;
  logic [DataWidth-1:0] pe_res_data;
  logic                 pe_res_valid;

  modport master (
    output pe_w_data, pe_i_data, pe_o_data,
    output pe_w_valid, pe_i_valid, pe_o_valid,
    input  pe_w_rdy, pe_i_rdy, pe_o_rdy,
    output pe_out_rdy,
    input  pe_res_data, pe_res_valid
  );

  modport slave (
    input  pe_w_data, pe_i_data, pe_o_data,
    input  pe_w_valid, pe_i_valid, pe_o_valid,
    output pe_w_rdy, pe_i_rdy, pe_o_rdy,
    input  pe_out_rdy,
    output pe_res_data, pe_res_valid
  );
endinterface

// File: rtl/pe_sched_skid.sv
// Two-entry valid/ready skid buffer fed by a 1-cycle-latency SRAM read; data is captured the cycle after rdIssue.
// hasFree counts the in-flight read so an issued read always has a landing slot; holds contents while outRdy is low.
module pe_sched_skid
  import pe_sched_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 rdIssue,
  input  logic [DataWidth-1:0] rdData,
  output logic                 outValid,
  input  logic                 outRdy,
  output logic [DataWidth-1:0] outData,
  output logic                 hasFree
);
  localparam int PtrW = $clog2(SkidDepth);
  localparam int CntW = $clog2(SkidDepth + 1);

  logic                 inFlight;
  logic [DataWidth-1:0] mem [SkidDepth];
  logic [PtrW-1:0]      wrPtr;
  logic [PtrW-1:0]      rdPtr;
  logic [CntW-1:0]      count;
  logic                 push;
  logic                 pop;

  assign push     = inFlight;
  assign pop      = outValid && outRdy;
  assign outValid = (count != '0);
  assign outData  = mem[rdPtr];
  assign hasFree  = ({1'b0, count} + {{CntW{1'b0}}, inFlight}) < (CntW + 1)'(SkidDepth);

  always_ff @(posedge clk) begin
    if (aclr) begin
      inFlight <= 1'b0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
    end else begin
      inFlight <= rdIssue;
      if (push) wrPtr <= wrPtr + PtrW'(1);
      if (pop)  rdPtr <= rdPtr + PtrW'(1);
      count <= count + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !aclr) mem[wrPtr] <= rdData;
  end

endmodule

// File: rtl/pe_conv1d_scheduler.sv
// Drives one PE through out[n] = bias + sum_k w[k]*x[n+k], tap-outer, with psums kept in external SRAM.
// Build macro PE_SCHED_RELU_EN clamps negative final-tap writebacks to zero; reads stall on full skid slots.
module pe_conv1d_scheduler
  import pe_sched_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 10,
  parameter int CntWidth  = 10
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 start,
  input  logic [CntWidth-1:0]  cfg_n,
  input  logic [CntWidth-1:0]  cfg_k,
  input  logic [DataWidth-1:0] cfg_bias,
  output logic                 busy,
  output logic                 done,
  output logic [AddrWidth-1:0] w_addr,
  output logic [AddrWidth-1:0] i_addr,
  output logic [AddrWidth-1:0] p_raddr,
  output logic                 w_rd,
  output logic                 i_rd,
  output logic                 p_rd,
  input  logic [DataWidth-1:0] w_rdata,
  input  logic [DataWidth-1:0] i_rdata,
  input  logic [DataWidth-1:0] p_rdata,
  output logic [AddrWidth-1:0] p_waddr,
  output logic                 p_we,
  output logic [DataWidth-1:0] p_wdata,
  pe_conv1d_scheduler_if.master pe
);
  schedState_t          state;
  schedState_t          nxtState;
  logic [CntWidth-1:0]  cfgN;
  logic [CntWidth-1:0]  cfgK;
  logic [DataWidth-1:0] cfgBias;
  logic [CntWidth-1:0]  nCnt;
  logic [CntWidth-1:0]  kCnt;
  logic [CntWidth-1:0]  collected;
  logic [DataWidth-1:0] oCapData;
  logic wFree, iFree, oFree;
  logic startJob, issue, lastIssue, lastTap;
  logic collecting, resAccept, drained, tapAdvance;

  assign startJob   = (state == IDLE) && start;
  assign collecting = (state == RUN) || (state == DRAIN);
  assign issue      = (state == RUN) && wFree && iFree && oFree;
  assign lastIssue  = (nCnt == cfgN - 1'b1);
  assign lastTap    = (kCnt == cfgK - 1'b1);
  assign resAccept  = collecting && pe.pe_res_valid;
  // Counting this cycle's writeback lets done land exactly one cycle after the final write.
  assign drained    = (collected == cfgN) || (resAccept && (collected == cfgN - 1'b1));
  assign tapAdvance = (state == DRAIN) && drained && !lastTap;

  always_comb begin
    nxtState = state;
    case (state)
      IDLE:    if (start) nxtState = RUN;
      RUN:     if (issue && lastIssue) nxtState = DRAIN;
      DRAIN:   if (drained) nxtState = lastTap ? DONE : RUN;
      DONE:    nxtState = IDLE;
      default: nxtState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      state     <= IDLE;
      cfgN      <= '0;
      cfgK      <= '0;
      cfgBias   <= '0;
      nCnt      <= '0;
      kCnt      <= '0;
      collected <= '0;
    end else begin
      state <= nxtState;
      if (startJob) begin
        cfgN      <= cfg_n;
        cfgK      <= cfg_k;
        cfgBias   <= cfg_bias;
        nCnt      <= '0;
        kCnt      <= '0;
        collected <= '0;
      end else begin
        if (issue) nCnt <= nCnt + 1'b1;
        if (tapAdvance) begin
          kCnt      <= kCnt + 1'b1;
          nCnt      <= '0;
          collected <= '0;
        end else if (resAccept) begin
          collected <= collected + 1'b1;
        end
      end
    end
  end

  assign w_addr  = AddrWidth'(kCnt);
  assign i_addr  = AddrWidth'(AddrWidth'(nCnt) + AddrWidth'(kCnt));
  assign p_raddr = AddrWidth'(nCnt);
  assign w_rd    = issue;
  assign i_rd    = issue;
  assign p_rd    = issue && (kCnt != '0);

  // k cannot change while a capture is pending, so the live tap selects bias vs stored psum.
  assign oCapData = (kCnt == '0) ? cfgBias : p_rdata;

  pe_sched_skid #(.DataWidth(DataWidth)) uSkidW (
    .clk(clk), .aclr(aclr), .rdIssue(issue), .rdData(w_rdata),
    .outValid(pe.pe_w_valid), .outRdy(pe.pe_w_rdy), .outData(pe.pe_w_data), .hasFree(wFree)
  );

  pe_sched_skid #(.DataWidth(DataWidth)) uSkidI (
    .clk(clk), .aclr(aclr), .rdIssue(issue), .rdData(i_rdata),
    .outValid(pe.pe_i_valid), .outRdy(pe.pe_i_rdy), .outData(pe.pe_i_data), .hasFree(iFree)
  );

  pe_sched_skid #(.DataWidth(DataWidth)) uSkidO (
    .clk(clk), .aclr(aclr), .rdIssue(issue), .rdData(oCapData),
    .outValid(pe.pe_o_valid), .outRdy(pe.pe_o_rdy), .outData(pe.pe_o_data), .hasFree(oFree)
  );

  assign p_we    = resAccept;
  assign p_waddr = AddrWidth'(collected);

  always_comb begin
    p_wdata = pe.pe_res_data;
`ifdef PE_SCHED_RELU_EN
    if (lastTap && pe.pe_res_data[DataWidth-1]) p_wdata = '0;
`endif
  end

  assign pe.pe_out_rdy = collecting;
  assign busy          = collecting;
  assign done          = (state == DONE);

endmodule

// File: tb/tb_pe_conv1d_scheduler.sv
// Bench for pe_conv1d_scheduler: SRAM + PE models, convolution scoreboard, directed jobs.
module tb_pe_conv1d_scheduler;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int CW = 10;
  localparam int MemSize = 1 << AW;

  typedef struct { int wa; int ia; int pa; bit prd; } op_t;
  typedef struct { int addr; logic [DW-1:0] data; } wb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          aclr, start;
  logic [CW-1:0] cfg_n, cfg_k;
  logic [DW-1:0] cfg_bias;
  logic          busy, done;
  logic [AW-1:0] w_addr, i_addr, p_raddr, p_waddr;
  logic          w_rd, i_rd, p_rd, p_we;
  logic [DW-1:0] w_rdata, i_rdata, p_rdata, p_wdata;

  pe_conv1d_scheduler_if #(.DataWidth(DW)) peIf ();

  pe_conv1d_scheduler #(.DataWidth(DW), .AddrWidth(AW), .CntWidth(CW)) dut (
    .clk(clk), .aclr(aclr), .start(start),
    .cfg_n(cfg_n), .cfg_k(cfg_k), .cfg_bias(cfg_bias),
    .busy(busy), .done(done),
    .w_addr(w_addr), .i_addr(i_addr), .p_raddr(p_raddr),
    .w_rd(w_rd), .i_rd(i_rd), .p_rd(p_rd),
    .w_rdata(w_rdata), .i_rdata(i_rdata), .p_rdata(p_rdata),
    .p_waddr(p_waddr), .p_we(p_we), .p_wdata(p_wdata),
    .pe(peIf)
  );

  int nCmp, nFail;
  int weCnt, hsW, hsI, hsO;
  bit wRandom, injectRes;
  logic [DW-1:0] wMem [MemSize];
  logic [DW-1:0] xMem [MemSize];
  logic [DW-1:0] pMem [MemSize];
  op_t expOps[$];
  wb_t expWb[$];
  op_t curOp;
  wb_t curWb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nCmp++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // SRAMs with one-cycle read latency
  always @(posedge clk) begin
    if (w_rd) w_rdata <= wMem[w_addr];
    if (i_rd) i_rdata <= xMem[i_addr];
    if (p_rd) p_rdata <= pMem[p_raddr];
    if (p_we) begin
      pMem[p_waddr] <= p_wdata;
      weCnt++;
    end
  end

  // PE model: collects one token per stream, emits o + w*x in order
  logic [DW-1:0] wQ[$], iQ[$], oQ[$], rQ[$];
  always @(posedge clk) begin
    if (aclr) begin
      wQ.delete(); iQ.delete(); oQ.delete(); rQ.delete();
      peIf.pe_res_valid <= 1'b0;
      peIf.pe_res_data  <= '0;
      peIf.pe_w_rdy <= 1'b1;
      peIf.pe_i_rdy <= 1'b1;
      peIf.pe_o_rdy <= 1'b1;
    end else begin
      if (injectRes) begin
        peIf.pe_res_valid <= 1'b1;
        peIf.pe_res_data  <= 32'h0000_00AB;
      end else if (rQ.size() > 0) begin
        peIf.pe_res_valid <= 1'b1;
        peIf.pe_res_data  <= rQ.pop_front();
      end else begin
        peIf.pe_res_valid <= 1'b0;
      end
      if (peIf.pe_w_valid && peIf.pe_w_rdy) begin wQ.push_back(peIf.pe_w_data); hsW++; end
      if (peIf.pe_i_valid && peIf.pe_i_rdy) begin iQ.push_back(peIf.pe_i_data); hsI++; end
      if (peIf.pe_o_valid && peIf.pe_o_rdy) begin oQ.push_back(peIf.pe_o_data); hsO++; end
      if (wQ.size() > 0 && iQ.size() > 0 && oQ.size() > 0)
        rQ.push_back(oQ.pop_front() + wQ.pop_front() * iQ.pop_front());
      peIf.pe_w_rdy <= wRandom ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Psum for output n after tap k: straight sum of products
  function automatic logic [DW-1:0] expVal(input int n, input int k, input logic [DW-1:0] b, input bit last);
    logic [DW-1:0] s;
    s = b;
    for (int j = 0; j <= k; j++) s = s + wMem[j] * xMem[(n + j) % MemSize];
`ifdef PE_SCHED_RELU_EN
    if (last && s[DW-1]) s = '0;
`endif
    return s;
  endfunction

  task automatic planJob(input int nn, input int kk, input logic [DW-1:0] b);
    expOps.delete();
    expWb.delete();
    for (int k = 0; k < kk; k++)
      for (int n = 0; n < nn; n++) begin
        expOps.push_back('{k, (n + k) % MemSize, n, (k != 0)});
        expWb.push_back('{n, expVal(n, k, b, (k == kk - 1))});
      end
  endtask

  always @(negedge clk) begin
    if (!aclr) begin
      if (w_rd) begin
        if (expOps.size() == 0) chk("op_unexpected", w_rd, 0);
        else begin
          curOp = expOps.pop_front();
          chk("w_addr", w_addr, curOp.wa);
          chk("i_addr", i_addr, curOp.ia);
          chk("p_raddr", p_raddr, curOp.pa);
          chk("p_rd", p_rd, curOp.prd);
          chk("i_rd", i_rd, 1);
        end
      end
      if (p_we) begin
        if (expWb.size() == 0) chk("wb_unexpected", p_we, 0);
        else begin
          curWb = expWb.pop_front();
          chk("p_waddr", p_waddr, curWb.addr);
          chk("p_wdata", p_wdata, curWb.data);
        end
      end
    end
  end

  task automatic runJob(input int nn, input int kk, input logic [DW-1:0] b, input bit pokeStart, input string tag);
    int doneCnt, cyc, lastWe;
    bit seenDone;
    doneCnt = 0; cyc = 0; lastWe = -100; seenDone = 0;
    planJob(nn, kk, b);
    weCnt = 0; hsW = 0; hsI = 0; hsO = 0;
    @(negedge clk);
    cfg_n = CW'(nn); cfg_k = CW'(kk); cfg_bias = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_rise"}, busy, 1);
    while (!seenDone && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      start = pokeStart && (cyc == 4);
      if (pokeStart && cyc == 4) cfg_n = CW'(nn + 3);
      if (p_we) lastWe = cyc;
      if (done) begin
        seenDone = 1;
        doneCnt++;
        chk({tag, "_done_latency"}, cyc - lastWe, 1);
        chk({tag, "_busy_at_done"}, busy, 0);
      end else begin
        chk({tag, "_busy_held"}, busy, 1);
      end
    end
    start = 1'b0;
    if (!seenDone) chk({tag, "_done_timeout"}, done, 1);
    repeat (3) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    chk({tag, "_done_count"}, doneCnt, 1);
    chk({tag, "_ops_left"}, expOps.size(), 0);
    chk({tag, "_wb_left"}, expWb.size(), 0);
  endtask

  task automatic clearMem();
    for (int i = 0; i < MemSize; i++) begin
      wMem[i] = '0; xMem[i] = '0; pMem[i] = '0;
    end
  endtask

  task automatic chkIdleOutputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_w_rd"}, w_rd, 0);
    chk({tag, "_i_rd"}, i_rd, 0);
    chk({tag, "_p_rd"}, p_rd, 0);
    chk({tag, "_p_we"}, p_we, 0);
    chk({tag, "_w_valid"}, peIf.pe_w_valid, 0);
    chk({tag, "_i_valid"}, peIf.pe_i_valid, 0);
    chk({tag, "_o_valid"}, peIf.pe_o_valid, 0);
    chk({tag, "_out_rdy"}, peIf.pe_out_rdy, 0);
  endtask

  task automatic loadConv4x3();
    clearMem();
    for (int i = 0; i < 3; i++) wMem[i] = DW'(i + 1);
    for (int i = 0; i < 6; i++) xMem[i] = DW'(i + 1);
  endtask

  int exp4x3 [4] = '{14, 20, 26, 32};

  initial begin
    int cyc;
    nCmp = 0; nFail = 0;
    aclr = 1'b1; start = 1'b0; cfg_n = '0; cfg_k = '0; cfg_bias = '0;
    wRandom = 0; injectRes = 0;
    weCnt = 0; hsW = 0; hsI = 0; hsO = 0;
    clearMem();
    repeat (3) @(negedge clk);
    aclr = 1'b0;
    chkIdleOutputs("reset");

    // result strobe while idle must not write
    injectRes = 1;
    @(negedge clk);
    injectRes = 0;
    chk("idle_res_valid", peIf.pe_res_valid, 1);
    chk("idle_res_no_we", p_we, 0);

    loadConv4x3();
    runJob(4, 3, 0, 0, "conv4x3");
    for (int n = 0; n < 4; n++) chk($sformatf("conv4x3_psum%0d", n), pMem[n], exp4x3[n]);
    chk("conv4x3_hsW", hsW, 12);

    loadConv4x3();
    wRandom = 1;
    runJob(4, 3, 0, 0, "wstall");
    wRandom = 0;
    for (int n = 0; n < 4; n++) chk($sformatf("wstall_psum%0d", n), pMem[n], exp4x3[n]);
    chk("wstall_hsW", hsW, 12);
    chk("wstall_hsI", hsI, 12);
    chk("wstall_hsO", hsO, 12);

    loadConv4x3();
    runJob(4, 3, 0, 1, "poke");
    for (int n = 0; n < 4; n++) chk($sformatf("poke_psum%0d", n), pMem[n], exp4x3[n]);

    clearMem();
    wMem[0] = 2; xMem[0] = 7;
    runJob(1, 1, 5, 0, "single");
    chk("single_psum0", pMem[0], 19);
    chk("single_we_count", weCnt, 1);

    // abort during tap 1 of an 8x4 job, then rerun it
    clearMem();
    for (int i = 0; i < 4; i++) wMem[i] = DW'(i + 1);
    for (int i = 0; i < 11; i++) xMem[i] = DW'(i + 1);
    planJob(8, 4, 0);
    @(negedge clk);
    cfg_n = 8; cfg_k = 4; cfg_bias = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(w_rd && w_addr == 1) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 2000) chk("abort_tap1_timeout", w_rd, 1);
    aclr = 1'b1;
    @(posedge clk);
    #1;
    chkIdleOutputs("abort");
    @(negedge clk);
    aclr = 1'b0;
    runJob(8, 4, 0, 0, "rerun");
    for (int n = 0; n < 8; n++) chk($sformatf("rerun_psum%0d", n), pMem[n], 10 * n + 30);

    clearMem();
    wMem[0] = 32'hFFFF_FFFF;
    xMem[0] = 3;
    xMem[1] = 32'hFFFF_FFFC;
    runJob(2, 1, 0, 0, "relu");
`ifdef PE_SCHED_RELU_EN
    chk("relu_psum0", pMem[0], 0);
`else
    chk("relu_psum0", pMem[0], 32'hFFFF_FFFD);
`endif
    chk("relu_psum1", pMem[1], 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pe_conv1d_scheduler.md
Name: pe_conv1d_scheduler

Overview:
- Sequences one PE to compute a 1-D convolution: out[n] = bias + sum over k of w[k]*x[n+k], for n in 0..N-1 and k in 0..K-1.
- Loop order is tap-outer, output-inner. Each op sends one W/I/O token triple to the PE.
- Partial sums live in an external psum memory and are rewritten once per tap.
- Sits between the weight, input and psum SRAMs and the PE's W/I/O stream ports.

Parameters:
- DataWidth, 32, token width on all data paths.
- AddrWidth, 10, address width of the weight, input and psum memories.
- CntWidth, 10, width of the N and K counters.

Ports:
- clk  in  1  clock
- aclr  in  1  reset (name kept per codebase)
- start  in  1  pulse; sampled only in IDLE
- cfg_n  in  CntWidth  number of outputs N (>=1)
- cfg_k  in  CntWidth  number of taps K (>=1)
- cfg_bias  in  DataWidth  initial partial sum
- busy  out  1  high from start to done
- done  out  1  one-cycle pulse when complete
- w_addr / i_addr / p_raddr  out  AddrWidth  read addresses
- w_rd / i_rd / p_rd  out  1  read enables; data returns next cycle
- w_rdata / i_rdata / p_rdata  in  DataWidth  read data
- p_waddr  out  AddrWidth  psum write address
- p_we  out  1  psum write enable
- p_wdata  out  DataWidth  psum write data
- pe_w_data / pe_i_data / pe_o_data  out  DataWidth  PE W/I/O input tokens
- pe_w_valid / pe_i_valid / pe_o_valid  out  1  token valid
- pe_w_rdy / pe_i_rdy / pe_o_rdy  in  1  PE input ready
- pe_out_rdy  out  1  downstream ready to the PE; high in RUN and DRAIN
- pe_res_data  in  DataWidth  PE result
- pe_res_valid  in  1  PE result valid; always accepted

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; all counters 0; every valid, rd, we, busy, done and pe_out_rdy output 0.
- Reset mid-operation abandons the job. Tokens already inside the PE are not tracked; the PE is reset by the same aclr.
- States:
  - IDLE: on start, latch cfg_* and clear n, k, issued and collected. Go to RUN.
  - RUN: issue ops for tap k, n = 0..N-1. After the N-th issue go to DRAIN.
  - DRAIN: wait until collected == N. Then if k == K-1 go to DONE; else k++, n = 0, go to RUN.
  - DONE: pulse done for one cycle, drop busy, return to IDLE.
- Issue: reads for op (k,n) use w_addr=k, i_addr=n+k, p_raddr=n. No p_rd when k==0; pe_o_data = cfg_bias instead.
- Buffering: read data lands in a 2-entry skid buffer per stream (W, I, O).
  - A new read is issued only if that stream's buffer has a free slot, counting any read in flight.
  - All three reads of an op are issued together.
  - The three valids to the PE rise together. A stream pops when its valid&rdy handshake completes; streams may pop in different cycles.
- Collection: each pe_res_valid writes p_wdata = pe_res_data to p_waddr = collected, then collected++.
  - Result order is guaranteed in-order by the PE.
- Hazards: the DRAIN barrier guarantees that psum[n] for tap k+1 is never read before tap k's write.
  - A same-cycle read and write of the same address cannot occur.
- Boundaries:
  - N=1, K=1: one op, one writeback, done.
  - Address arithmetic n+k truncates to AddrWidth with no error.
  - start while busy is ignored.
  - pe_res_valid in IDLE is ignored (no write).
  - Stalls on any pe_*_rdy low hold addresses and buffer contents stable.
- Latency: done asserts 1 cycle after the last writeback of tap K-1.

Optional Feature:
- Macro: PE_SCHED_RELU_EN.
- When defined: on tap K-1 writebacks, if pe_res_data[DataWidth-1] is 1, p_wdata = 0. This covers both signed-int and FP sign.
- When undefined: data is written back unmodified.

Decomposition:
- Package pe_sched_pkg: state encoding (IDLE, RUN, DRAIN, DONE) and the skid depth constant (2).
- One sub-module: pe_sched_skid. It is a 2-entry valid/ready skid buffer with a 1-cycle-latency read-data capture and a free-slot output. It is instantiated three times.

Test Plan:
- N=4, K=3, bias=0, w={1,2,3}, x={1..6}, PE always ready -> psum = {14,20,26,32}; done once; busy high throughout.
- Same job with pe_w_rdy toggled at random 50% -> identical psum; no token dropped or duplicated (bench counts exactly 12 handshakes per stream).
- N=1, K=1, bias=5, w={2}, x={7} -> psum[0]=19; exactly one p_we.
- aclr asserted during the second tap of an N=8, K=4 job -> next cycle all outputs at reset values. A new start then runs to correct completion.
- With PE_SCHED_RELU_EN defined: N=2, K=1, w={-1}, x={3,-4} -> psum = {0,4}. Without the macro -> {-3,4}.
- start pulsed while busy -> ignored; only one done per job.
